// File: rtl/sap_pkg.sv
// Shared SAP datapath definitions: the MAR burst state encoding and default widths.
package sap_pkg;

    localparam int SAP_DATA_W = 16;
    localparam int SAP_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mar_state_t;

endpackage

// File: rtl/mar_burst_if.sv
// Bus-side and memory-side signals of the burst MAR; the sequencer/testbench is the
// master, mar_burst is the slave.
interface mar_burst_if #(
    parameter int DATA_W = sap_pkg::SAP_DATA_W,
    parameter int ADDR_W = sap_pkg::SAP_ADDR_W,
    parameter int LEN_W  = 4
);
    logic              mar_write;
    logic              mar_inc;
    logic [DATA_W-1:0] bus;
    logic              burst_start;
    logic [LEN_W-1:0]  burst_len;
    logic              mem_ack;
    logic [ADDR_W-1:0] mar_out;
    logic              mem_req;
    logic              busy;
    logic              burst_done;
    logic              wrapped;

    modport master (
        output mar_write, mar_inc, bus, burst_start, burst_len, mem_ack,
        input  mar_out, mem_req, busy, burst_done, wrapped
    );

    modport slave (
        input  mar_write, mar_inc, bus, burst_start, burst_len, mem_ack,
        output mar_out, mem_req, busy, burst_done, wrapped
    );
endinterface

// File: rtl/burst_counter.sv
// Remaining-words counter for a MAR burst: loads the length, counts down on each
// acknowledged word and flags the final word.
module burst_counter #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    input  logic             dec,
    output logic             last
);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    logic [LEN_W-1:0] count_r;

    // Load has priority; decrement never underflows below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= len;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign last = (count_r == ONE);
endmodule

// File: rtl/mar_burst.sv
// Memory address register with bus load, post-increment and counted req/ack bursts.
// Optional sticky wrap flag built when MAR_WRAP_FLAG_EN is defined.
module mar_burst
    import sap_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W,
    parameter int ADDR_W = SAP_ADDR_W,
    parameter int LEN_W  = 4
) (
    input  logic          clk,
    input  logic          rst,
    mar_burst_if.slave    bif
);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    mar_state_t        state_r;
    logic [ADDR_W-1:0] mar_r;
    logic              mem_req_r;
    logic              busy_r;
    logic              done_r;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic              inc_s;
    logic              wrap_s;
    logic              last_s;
    logic              cnt_load_s;
    logic              cnt_dec_s;

    assign cnt_load_s = (state_r == IDLE) && bif.burst_start && (bif.burst_len != '0);
    assign cnt_dec_s  = (state_r == REQ) && bif.mem_ack;

    burst_counter #(.LEN_W(LEN_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load_s),
        .len  (bif.burst_len),
        .dec  (cnt_dec_s),
        .last (last_s)
    );

    // Next address: load beats increment in IDLE; REQ steps only on ack.
    always_comb begin
        addr_nxt_s = mar_r;
        inc_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bif.mar_write) begin
                    addr_nxt_s = bif.bus[ADDR_W-1:0];
                end else if (bif.mar_inc) begin
                    addr_nxt_s = mar_r + ADDR_ONE;
                    inc_s      = 1'b1;
                end else begin
                    addr_nxt_s = mar_r;
                end
            end
            REQ: begin
                if (bif.mem_ack) begin
                    addr_nxt_s = mar_r + ADDR_ONE;
                    inc_s      = 1'b1;
                end else begin
                    addr_nxt_s = mar_r;
                end
            end
            default: begin
                addr_nxt_s = mar_r;
                inc_s      = 1'b0;
            end
        endcase
    end

    assign wrap_s = inc_s && (mar_r == '1);

    // Burst FSM with registered address, request, busy and done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            mar_r     <= '0;
            mem_req_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    mar_r <= addr_nxt_s;
                    if (bif.burst_start) begin
                        busy_r <= 1'b1;
                        if (bif.burst_len != '0) begin
                            state_r   <= REQ;
                            mem_req_r <= 1'b1;
                        end else begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    mar_r <= addr_nxt_s;
                    if (bif.mem_ack && last_s) begin
                        state_r   <= DONE;
                        mem_req_r <= 1'b0;
                        done_r    <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

`ifdef MAR_WRAP_FLAG_EN
    logic wrapped_r;

    // Sticky wrap flag; only an address load clears it, and a load wins over a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrapped_r <= 1'b0;
        end else if ((state_r == IDLE) && bif.mar_write) begin
            wrapped_r <= 1'b0;
        end else if (wrap_s) begin
            wrapped_r <= 1'b1;
        end else begin
            wrapped_r <= wrapped_r;
        end
    end

    assign bif.wrapped = wrapped_r;
`else
    logic unused_wrap_s;
    assign unused_wrap_s = wrap_s;
    assign bif.wrapped   = 1'b0;
`endif

    assign bif.mar_out    = mar_r;
    assign bif.mem_req    = mem_req_r;
    assign bif.busy       = busy_r;
    assign bif.burst_done = done_r;
endmodule
